// File: rtl/grid_arbiter_if.sv
// Requester-side command/response bundle plus the RAM port of the grid arbiter.
// The master modport is the environment side; the slave modport is the arbiter.
interface grid_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    lock;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               mem_re;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;

  modport master (
    output req, we, addr, wdata, lock, mem_rdata,
    input  gnt, rvalid, rdata, mem_re, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, we, addr, wdata, lock, mem_rdata,
    output gnt, rvalid, rdata, mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/grid_arbiter.sv
// Round-robin arbiter sharing the single-port grid RAM between NREQ placement engines.
// Define GRID_ARB_LOCK_EN to enable the IDLE/LOCKED ownership FSM for atomic read-check-write.
module grid_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 8,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input logic           clk,
  input logic           reset,
  grid_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            mem_re_q, mem_re_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] tag_q [RD_LAT];
  logic [NREQ-1:0] tag_d [RD_LAT];

  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] elig;
  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   cand;

`ifdef GRID_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_st_e;
  lock_st_e      st_q, st_d;
  logic [PW-1:0] owner_q, owner_d;
  logic          lock_hold;

  // The cycle the owner drops lock is already arbitrated with IDLE rules.
  always_comb begin
    lock_hold = (st_q == LOCKED) && bus.lock[owner_q];
    mask      = lock_hold ? (NREQ'(1) << owner_q) : '1;
    st_d      = st_q;
    owner_d   = owner_q;
    if ((st_q == LOCKED) && !bus.lock[owner_q]) begin
      st_d = IDLE;
    end
    if (found && bus.lock[win]) begin
      st_d    = LOCKED;
      owner_d = win;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign mask        = '1;
`endif

  // Last cycle's grantee is masked so nobody is granted on consecutive cycles.
  always_comb begin
    elig  = bus.req & ~gnt_q & mask;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    gnt_d       = '0;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ptr_d       = ptr_q;
    if (found) begin
      gnt_d       = NREQ'(1) << win;
      mem_re_d    = ~bus.we[win];
      mem_we_d    = bus.we[win];
      mem_addr_d  = bus.addr[win*AW +: AW];
      mem_wdata_d = bus.wdata[win*DW +: DW];
      ptr_d       = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    end
  end

  // Tag stage 0 lines up with the RAM sampling the read; the last stage with valid mem_rdata.
  always_comb begin
    tag_d[0] = gnt_q & {NREQ{mem_re_q}};
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    rvalid_d = tag_q[RD_LAT-1];
    rdata_d  = (|tag_q[RD_LAT-1]) ? bus.mem_rdata : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ptr_q       <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
`ifdef GRID_ARB_LOCK_EN
      st_q        <= IDLE;
      owner_q     <= '0;
`endif
    end else begin
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ptr_q       <= ptr_d;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
`ifdef GRID_ARB_LOCK_EN
      st_q        <= st_d;
      owner_q     <= owner_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_grid_arbiter.sv
// Bench for grid_arbiter (NREQ=4, RD_LAT=1): per-requester command queues, a RAM model,
// and per-requester expected read-data queues filled from a shadow memory when commands are queued.
module tb_grid_arbiter;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  logic clk;
  logic reset;

  grid_arbiter_if #(.NREQ(4), .AW(8), .DW(32)) bus ();

  grid_arbiter #(.NREQ(4), .AW(8), .DW(32), .RD_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_err;
  cmd_t        cmd_q [4][$];
  logic [31:0] exp_q [4][$];
  logic [31:0] ram    [256];
  logic [31:0] shadow [256];
  logic [31:0] rd_pend;
  logic        rd_pend_vld;
  logic [3:0]  rd_h1, rd_h2;
  logic [3:0]  lock_r;

  logic [3:0] s2 [12] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd0, 4'd0, 4'd0};
  logic [3:0] s3 [7]  = '{4'd4, 4'd0, 4'd4, 4'd0, 4'd4, 4'd0, 4'd0};
`ifdef GRID_ARB_LOCK_EN
  localparam int S6N = 13;
  logic [3:0] s6 [S6N] = '{4'd8, 4'd0, 4'd8, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
`else
  localparam int S6N = 11;
  logic [3:0] s6 [S6N] = '{4'd8, 4'd1, 4'd8, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp_v, $time);
    end
  endtask

  task automatic drive();
    logic [3:0]   r, w;
    logic [31:0]  a;
    logic [127:0] d;
    cmd_t         c;
    r = '0;
    w = bus.we;
    a = bus.addr;
    d = bus.wdata;
    for (int i = 0; i < 4; i++) begin
      if (cmd_q[i].size() > 0) begin
        c = cmd_q[i][0];
        r[i] = 1'b1;
        w[i] = c.we;
        a[i*8 +: 8]   = c.addr;
        d[i*32 +: 32] = c.wdata;
      end
    end
    bus.req   = r;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    bus.lock  = lock_r;
  endtask

  task automatic push_cmd(input int i, input logic w, input logic [7:0] a, input logic [31:0] d);
    cmd_t c;
    c.we = w;
    c.addr = a;
    c.wdata = d;
    cmd_q[i].push_back(c);
    if (w) shadow[a] = d;
    else   exp_q[i].push_back(shadow[a]);
  endtask

  task automatic step(input logic do_chk, input logic [3:0] eg, input string tag);
    cmd_t       c;
    logic [3:0] g;
    @(negedge clk);
    if (do_chk) chk(tag, 32'(bus.gnt), 32'(eg));
    chk("rv_lat", 32'(bus.rvalid), 32'(rd_h2));
    for (int i = 0; i < 4; i++) begin
      if (bus.rvalid[i]) begin
        if (exp_q[i].size() > 0) chk($sformatf("rdata%0d", i), bus.rdata, exp_q[i].pop_front());
        else chk("rv_spurious", 32'(bus.rvalid), 32'd0);
      end
    end
    rd_h2 = rd_h1;
    rd_h1 = bus.gnt & {4{bus.mem_re}};
    g = bus.gnt;
    if (g == 4'd0) begin
      chk("mem_idle", 32'({bus.mem_re, bus.mem_we}), 32'd0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (g[i]) begin
          if (cmd_q[i].size() == 0) begin
            chk("gnt_spurious", 32'(g), 32'd0);
          end else begin
            c = cmd_q[i].pop_front();
            chk("mem_we", 32'(bus.mem_we), 32'(c.we));
            chk("mem_re", 32'(bus.mem_re), 32'(!c.we));
            chk("mem_addr", 32'(bus.mem_addr), 32'(c.addr));
            if (c.we) chk("mem_wdata", bus.mem_wdata, c.wdata);
          end
        end
      end
    end
    // RAM model: data of a read seen this cycle is presented during the next cycle.
    bus.mem_rdata = rd_pend_vld ? rd_pend : 32'hDEAD_BEEF;
    rd_pend_vld = 1'b0;
    if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
    if (bus.mem_re) begin
      rd_pend     = ram[bus.mem_addr];
      rd_pend_vld = 1'b1;
    end
    drive();
  endtask

  task automatic check_idle(input string pfx);
    chk({pfx, "_gnt"},    32'(bus.gnt), 32'd0);
    chk({pfx, "_rvalid"}, 32'(bus.rvalid), 32'd0);
    chk({pfx, "_rdata"},  bus.rdata, 32'd0);
    chk({pfx, "_mem_re"}, 32'(bus.mem_re), 32'd0);
    chk({pfx, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({pfx, "_addr"},   32'(bus.mem_addr), 32'd0);
    chk({pfx, "_wdata"},  bus.mem_wdata, 32'd0);
  endtask

  initial begin
    int left;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    lock_r = '0;
    rd_h1 = '0;
    rd_h2 = '0;
    rd_pend = '0;
    rd_pend_vld = 1'b0;
    bus.req = '0;
    bus.we = '0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.lock = '0;
    bus.mem_rdata = '0;
    for (int a = 0; a < 256; a++) begin
      ram[a]    = 32'(a) * 32'd17 + 32'd1;
      shadow[a] = ram[a];
    end
    ram[8'h12] = 32'd5;          shadow[8'h12] = 32'd5;
    ram[8'h07] = 32'hFFFF_FFFF;  shadow[8'h07] = 32'hFFFF_FFFF;

    step(1'b1, 4'd0, "rst_gnt0");
    check_idle("rst0");
    step(1'b1, 4'd0, "rst_gnt1");
    check_idle("rst1");
    reset = 1'b0;

    // Single read by requester 0 from 0x12.
    push_cmd(0, 1'b0, 8'h12, 32'd0);
    drive();
    step(1'b1, 4'b0001, "s1_gnt");
    step(1'b1, 4'b0000, "s1_gap");
    step(1'b1, 4'b0000, "s1_rv");

    // Requester 2 alone, holding req: granted every other cycle.
    for (int j = 0; j < 3; j++) push_cmd(2, 1'b0, 8'(8'h20 + j), 32'd0);
    drive();
    for (int k = 0; k < 7; k++) step(1'b1, s3[k], $sformatf("s3_gnt%0d", k));

    // Write 0x07=3 by requester 1, then read back by requester 0.
    push_cmd(1, 1'b1, 8'h07, 32'd3);
    drive();
    step(1'b1, 4'b0010, "s4_wr");
    push_cmd(0, 1'b0, 8'h07, 32'd0);
    drive();
    step(1'b1, 4'b0001, "s4_rd");
    step(1'b1, 4'b0000, "s4_g0");
    step(1'b1, 4'b0000, "s4_g1");

    // Reset one cycle after a read grant: the read must never return.
    push_cmd(1, 1'b0, 8'h12, 32'd0);
    drive();
    step(1'b1, 4'b0010, "s5_gnt");
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_q[i].delete();
      exp_q[i].delete();
    end
    rd_h1 = '0;
    rd_h2 = '0;
    rd_pend_vld = 1'b0;
    drive();
    #1;
    check_idle("s5_async");
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'd0, "s5_rst_gnt");
      chk("s5_rst_rvalid", 32'(bus.rvalid), 32'd0);
    end
    reset = 1'b0;
    step(1'b1, 4'd0, "s5_post_gnt");
    check_idle("s5_post");

    // All four read continuously: after reset the pointer starts at 0.
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 4; i++) begin
        if (j < 2 || i == 0) push_cmd(i, 1'b0, 8'(8'h40 + i*4 + j), 32'd0);
      end
    end
    drive();
    for (int k = 0; k < 12; k++) step(1'b1, s2[k], $sformatf("s2_gnt%0d", k));

    // Requester 3 locks for read-then-write of 0x12 while requester 0 keeps requesting.
    lock_r[3] = 1'b1;
    push_cmd(3, 1'b0, 8'h12, 32'd0);
    push_cmd(3, 1'b1, 8'h12, 32'd9);
    for (int j = 0; j < 4; j++) push_cmd(0, 1'b0, 8'(8'h30 + j), 32'd0);
    drive();
    for (int k = 0; k < S6N; k++) begin
      step(1'b1, s6[k], $sformatf("s6_gnt%0d", k));
      if (k == 2) begin
        lock_r[3] = 1'b0;
        drive();
      end
    end

    left = 0;
    for (int i = 0; i < 4; i++) left += exp_q[i].size() + cmd_q[i].size();
    chk("sb_left", 32'(left), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/grid_arbiter.md
Name: grid_arbiter

Overview:
- Round-robin arbiter that shares the single-port grid RAM (cell array, DW-bit signed entries, -1 = empty) between NREQ placement engines.
- Serialises read/write commands onto the RAM port.
- Routes read data back to the issuing requester.
- Sits between the placement FSMs and the grid memoryRAM instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 8, grid address width (matches grid data_depth)
- DW, 32, grid data width
- RD_LAT, 1, RAM cycles from mem_re to valid mem_rdata (1..4)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- req  input  NREQ  per-requester access request, level, held until gnt
- we  input  NREQ  per-requester 1 = write, 0 = read
- addr  input  NREQ*AW  per-requester address, slice i = bits [i*AW +: AW]
- wdata  input  NREQ*DW  per-requester write data, slice i = bits [i*DW +: DW]
- lock  input  NREQ  per-requester lock request (see Optional Feature)
- gnt  output  NREQ  one-hot, 1-cycle grant pulse
- rvalid  output  NREQ  one-hot, 1-cycle read-data-valid pulse
- rdata  output  DW  read data, shared by all requesters, qualified by rvalid
- mem_re  output  1  RAM read strobe
- mem_we  output  1  RAM write strobe
- mem_addr  output  AW  RAM address
- mem_wdata  output  DW  RAM write data
- mem_rdata  input  DW  RAM read data

Behaviour:
- Reset values: gnt=0, rvalid=0, rdata=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0; priority pointer=0; previous-grantee mask clear; read-tag pipeline empty; lock state IDLE.
- All outputs are registered.
- Arbitration, each cycle:
  - eligible = req & ~prev_gnt.
  - The winner is the first eligible index at or after the pointer, wrapping modulo NREQ.
  - On the next edge: gnt[w]=1, mem_re=~we[w], mem_we=we[w], mem_addr=addr slice w, mem_wdata=wdata slice w.
  - Pointer becomes (w+1) mod NREQ.
  - No eligible requester: mem_re=mem_we=0, gnt=0, pointer unchanged.
- prev_gnt is the gnt vector of the previous cycle. Each requester therefore gets at most one grant every 2 cycles, while other requesters may take consecutive cycles.
- A requester drops req or presents its next command in the cycle after gnt. Command inputs are sampled only in the arbitration cycle.
- Read return:
  - A tag pipeline of depth RD_LAT carries the one-hot grantee of every read.
  - When the tag emerges, rvalid[tag]=1 and rdata=mem_rdata, registered one cycle after mem_rdata is valid.
  - Read-to-rvalid latency is RD_LAT+1 cycles after gnt.
  - Writes produce no rvalid.
  - rdata holds its value when rvalid=0.
- Ordering: commands reach the RAM in grant order. A write granted after a read to the same address never affects that read's data. A read granted after a write sees the new value.
- Simultaneous events: a read return and a new grant in the same cycle are independent and both occur.
- reset asserted mid-operation drops all in-flight reads (no rvalid is generated for them) and releases any lock.
- NREQ=1: the single requester is granted at most every other cycle.

Optional Feature:
- Macro: GRID_ARB_LOCK_EN.
- Enabled, two-state FSM IDLE/LOCKED:
  - If the winner has lock[w]=1 at grant time, move to LOCKED with owner=w.
  - In LOCKED, only the owner is eligible. The prev_gnt mask still applies, so the owner gets at most one grant every 2 cycles.
  - LOCKED returns to IDLE on the first cycle in which lock[owner]=0. The arbitration in that cycle already uses IDLE rules.
  - Purpose: an atomic read-check-write of a grid cell.
- Disabled: the lock port exists but is ignored, there is no FSM, and arbitration is always round-robin.

Test Plan:
- Reset, then req=4'b0001, we=0, addr0=8'h12, mem_rdata=5 (RD_LAT=1) -> gnt=0001 and mem_re=1 with mem_addr=12 on the first edge; rvalid=0001 and rdata=5 two cycles later.
- req=4'b1111, all reads, held continuously -> grant order 0,1,2,3,0,… with one grant per cycle; each rvalid matches its grant 2 cycles earlier.
- Requester 2 only, holding req -> gnt[2] every other cycle; mem_re=0 in the gaps.
- Requester 1 writes addr 8'h07 = 3, then requester 0 reads addr 8'h07 -> mem_we then mem_re in order; rvalid[0] with rdata=3.
- Reset asserted one cycle after a read grant -> rvalid stays 0; after reset the pointer is 0 and outputs are 0.
- With GRID_ARB_LOCK_EN: requester 3 takes lock and reads, while requester 0 requests continuously -> requester 0 gets no grant until lock[3] drops; requester 3's write is granted 2 cycles after its read; requester 0 is granted on the first cycle lock[3]=0.
